// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-back control path.
package regfile_ctrl_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

  // Which requester owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A new producer (issue) takes precedence over a completing write-back to
// the same register, and register 0 can never be marked busy.
module wb_scoreboard #(
  parameter int ADDR_W   = regfile_ctrl_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_ctrl_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_register,
  input  logic                clear_valid,
  input  logic [ADDR_W-1:0]   clear_register,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Register 0 is hard-wired zero, so its bit never becomes busy.
  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = issue_valid && (issue_register == ADDR_W'(gi));
      assign clr_hit = clear_valid && (clear_register == ADDR_W'(gi));
      // Set wins over clear: the issuing instruction is the newer producer.
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  endgenerate

  // Busy-bit state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_mask = busy_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// The load unit has fixed priority over the ALU, except when the ALU has
// lost STARVE_LIMIT consecutive cycles; then the ALU is forced through.
// The accepted request is registered onto the write port one cycle later
// and also retires the destination's busy bit in the scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W       = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W       = regfile_ctrl_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluRegister,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memRegister,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueRegister,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic [31:0]       busyMask
);

  import regfile_ctrl_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_src_t           grant;
  logic [CNT_W-1:0]  starve_cnt;
  logic              hs_valid;
  logic [ADDR_W-1:0] hs_register;
  logic [DATA_W-1:0] hs_data;

  // Grant selection: single requester always wins; on a collision the load
  // unit wins unless the ALU has been starved long enough. No grant in reset.
  always_comb begin
    grant = SRC_NONE;
    if (reset) begin
      grant = SRC_NONE;
    end else if (aluValid && memValid) begin
      grant = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? SRC_ALU : SRC_MEM;
    end else if (aluValid) begin
      grant = SRC_ALU;
    end else if (memValid) begin
      grant = SRC_MEM;
    end
  end

  assign aluReady = (grant == SRC_ALU);
  assign memReady = (grant == SRC_MEM);

  // Mux the winning request; the grant only names a source that is valid.
  always_comb begin
    hs_valid    = 1'b0;
    hs_register = memRegister;
    hs_data     = memData;
    if (grant == SRC_ALU) begin
      hs_valid    = 1'b1;
      hs_register = aluRegister;
      hs_data     = aluData;
    end else if (grant == SRC_MEM) begin
      hs_valid    = 1'b1;
    end
  end

  // Count consecutive cycles the ALU waits; saturate at the forcing threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!aluValid || aluReady) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port: address/data hold when idle, strobe only for a
  // real (non-zero) destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else if (hs_valid) begin
      regWrite      <= (hs_register != ADDR_W'(REG_ZERO));
      writeRegister <= hs_register;
      writeData     <= hs_data;
    end else begin
      regWrite      <= 1'b0;
    end
  end

  wb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issueValid),
    .issue_register (issueRegister),
    .clear_valid    (hs_valid),
    .clear_register (hs_register),
    .busy_mask      (busyMask)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        aluValid;
  logic [4:0]  aluRegister;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memRegister;
  logic [31:0] memData;
  logic        memReady;
  logic        issueValid;
  logic [4:0]  issueRegister;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] busyMask;

  int n_vec;
  int n_err;

  regfile_wb_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .aluValid      (aluValid),
    .aluRegister   (aluRegister),
    .aluData       (aluData),
    .aluReady      (aluReady),
    .memValid      (memValid),
    .memRegister   (memRegister),
    .memData       (memData),
    .memReady      (memReady),
    .issueValid    (issueValid),
    .issueRegister (issueRegister),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .busyMask      (busyMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    aluValid = 1'b0; aluRegister = '0; aluData = '0;
    memValid = 1'b0; memRegister = '0; memData = '0;
    issueValid = 1'b0; issueRegister = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    aluValid = 1'b1; aluRegister = 5'd3;
    memValid = 1'b1; memRegister = 5'd4;
    tick();
    n_vec++;
    if (aluReady !== 1'b0 || memReady !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: alu=%b mem=%b expected 0 0", aluReady, memReady);
    end
    idle();
    reset = 1'b0;
    tick();
    n_vec++;
    if (regWrite !== 1'b0 || busyMask !== 32'h0 || writeRegister !== 5'd0 || writeData !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: we=%b reg=%0d data=%h busy=%h expected 0 0 0 0",
               regWrite, writeRegister, writeData, busyMask);
    end
    $display("reset: released, outputs idle");
  endtask

  task automatic test_reset_midcycle();
    idle();
    aluValid = 1'b1; aluRegister = 5'd4; aluData = 32'hCAFE_0004;
    issueValid = 1'b1; issueRegister = 5'd3;
    tick();
    idle();
    n_vec++;
    if (regWrite !== 1'b1 || busyMask !== 32'h8) begin
      n_err++;
      $display("FAIL midreset_pre: we=%b busy=%h expected 1 00000008", regWrite, busyMask);
    end
    aluValid = 1'b1; aluRegister = 5'd6; aluData = 32'h1111_2222;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (regWrite !== 1'b0 || writeRegister !== 5'd0 || writeData !== 32'h0 ||
        busyMask !== 32'h0 || aluReady !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: we=%b reg=%0d data=%h busy=%h ardy=%b expected all 0",
               regWrite, writeRegister, writeData, busyMask, aluReady);
    end
    tick();
    idle();
    reset = 1'b0;
    tick();
    n_vec++;
    if (regWrite !== 1'b0 || writeRegister !== 5'd0) begin
      n_err++;
      $display("FAIL midreset_discard: we=%b reg=%0d expected 0 0", regWrite, writeRegister);
    end
    $display("reset_midcycle: asynchronous clear checked");
  endtask

  task automatic test_collision();
    idle();
    aluValid = 1'b1; aluRegister = 5'd5; aluData = 32'h0000_AAAA;
    memValid = 1'b1; memRegister = 5'd6; memData = 32'h0000_1234;
    #1;
    n_vec++;
    if (memReady !== 1'b1 || aluReady !== 1'b0) begin
      n_err++;
      $display("FAIL collision_grant: mem=%b alu=%b expected 1 0", memReady, aluReady);
    end
    tick();
    memValid = 1'b0;
    n_vec++;
    if (regWrite !== 1'b1 || writeRegister !== 5'd6 || writeData !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL collision_mem_write: we=%b reg=%0d data=%h expected 1 6 00001234",
               regWrite, writeRegister, writeData);
    end
    #1;
    n_vec++;
    if (aluReady !== 1'b1) begin
      n_err++;
      $display("FAIL collision_alu_grant: alu=%b expected 1", aluReady);
    end
    tick();
    idle();
    n_vec++;
    if (regWrite !== 1'b1 || writeRegister !== 5'd5 || writeData !== 32'h0000_AAAA) begin
      n_err++;
      $display("FAIL collision_alu_write: we=%b reg=%0d data=%h expected 1 5 0000aaaa",
               regWrite, writeRegister, writeData);
    end
    tick();
    n_vec++;
    if (regWrite !== 1'b0 || writeRegister !== 5'd5 || writeData !== 32'h0000_AAAA) begin
      n_err++;
      $display("FAIL collision_hold: we=%b reg=%0d data=%h expected 0 5 0000aaaa",
               regWrite, writeRegister, writeData);
    end
    $display("collision: mem first, alu second, port holds when idle");
  endtask

  task automatic test_starvation();
    // Mem presents 1..8 and holds each until accepted; ALU wants reg 7.
    // ALU loses cycles 0..3 and is forced through in cycle 4.
    logic [4:0] exp_seq [9];
    logic [4:0] mem_reg;
    logic       alu_done;
    exp_seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd5, 5'd6, 5'd7, 5'd8};
    mem_reg  = 5'd1;
    alu_done = 1'b0;
    idle();
    tick();
    for (int c = 0; c < 9; c++) begin
      logic exp_alu;
      logic [31:0] exp_data;
      exp_alu = (c == 4);
      aluValid = !alu_done; aluRegister = 5'd7; aluData = 32'hA1A1_0007;
      memValid = 1'b1; memRegister = mem_reg; memData = {27'h0BEEF00, mem_reg};
      exp_data = exp_alu ? 32'hA1A1_0007 : {27'h0BEEF00, exp_seq[c]};
      #1;
      n_vec++;
      if (aluReady !== exp_alu || memReady !== !exp_alu) begin
        n_err++;
        $display("FAIL starve_grant c=%0d: alu=%b mem=%b expected %b %b",
                 c, aluReady, memReady, exp_alu, !exp_alu);
      end
      if (memReady) mem_reg = mem_reg + 5'd1;
      if (aluReady) alu_done = 1'b1;
      tick();
      n_vec++;
      if (regWrite !== 1'b1 || writeRegister !== exp_seq[c] || writeData !== exp_data) begin
        n_err++;
        $display("FAIL starve_write c=%0d: we=%b reg=%0d data=%h expected 1 %0d %h",
                 c, regWrite, writeRegister, writeData, exp_seq[c], exp_data);
      end
      $display("starvation cycle %0d: wrote reg %0d", c, writeRegister);
    end
    idle();
    tick();
  endtask

  task automatic test_reg_zero();
    idle();
    aluValid = 1'b1; aluRegister = 5'd0; aluData = 32'hFFFF_FFFF;
    #1;
    n_vec++;
    if (aluReady !== 1'b1) begin
      n_err++;
      $display("FAIL zero_ready: alu=%b expected 1", aluReady);
    end
    tick();
    idle();
    issueValid = 1'b1; issueRegister = 5'd0;
    n_vec++;
    if (regWrite !== 1'b0 || writeRegister !== 5'd0 || writeData !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL zero_write: we=%b reg=%0d data=%h expected 0 0 ffffffff",
               regWrite, writeRegister, writeData);
    end
    tick();
    idle();
    n_vec++;
    if (busyMask !== 32'h0) begin
      n_err++;
      $display("FAIL zero_issue: busy=%h expected 00000000", busyMask);
    end
    $display("reg_zero: no write strobe, no busy bit");
  endtask

  task automatic test_scoreboard();
    idle();
    issueValid = 1'b1; issueRegister = 5'd9;
    tick();
    n_vec++;
    if (busyMask !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL sb_set: busy=%h expected 00000200", busyMask);
    end
    memValid = 1'b1; memRegister = 5'd9; memData = 32'h0909_0909;
    issueValid = 1'b1; issueRegister = 5'd9;
    tick();
    n_vec++;
    if (busyMask !== 32'h0000_0200 || regWrite !== 1'b1 || writeRegister !== 5'd9) begin
      n_err++;
      $display("FAIL sb_set_wins: busy=%h we=%b reg=%0d expected 00000200 1 9",
               busyMask, regWrite, writeRegister);
    end
    issueValid = 1'b0;
    memData = 32'h9999_0000;
    tick();
    idle();
    n_vec++;
    if (busyMask !== 32'h0 || regWrite !== 1'b1 || writeData !== 32'h9999_0000) begin
      n_err++;
      $display("FAIL sb_clear: busy=%h we=%b data=%h expected 00000000 1 99990000",
               busyMask, regWrite, writeData);
    end
    $display("scoreboard: set, set-over-clear, clear");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    idle();
    for (int i = 1; i <= 16; i++) begin
      d = $urandom;
      aluValid = 1'b1; aluRegister = 5'(i); aluData = d;
      #1;
      n_vec++;
      if (aluReady !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready i=%0d: alu=%b expected 1", i, aluReady);
      end
      tick();
      n_vec++;
      if (regWrite !== 1'b1 || writeRegister !== 5'(i) || writeData !== d) begin
        n_err++;
        $display("FAIL b2b_write i=%0d: we=%b reg=%0d data=%h expected 1 %0d %h",
                 i, regWrite, writeRegister, writeData, i, d);
      end
    end
    idle();
    tick();
    n_vec++;
    if (regWrite !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: we=%b expected 0", regWrite);
    end
    $display("back_to_back: 16 writes without bubbles");
  endtask

  task automatic test_random();
    // Model state: consecutive ALU losses, expected port contents, busy bits.
    int          lost;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_busy [32];
    logic [31:0] exp_mask;
    idle();
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    lost = 0; m_we = 0; m_reg = '0; m_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    tick();
    for (int c = 0; c < 400; c++) begin
      bit alu_win, mem_win;
      aluValid = ($urandom_range(0, 9) < 6);
      aluRegister = 5'($urandom_range(0, 31));
      aluData = $urandom;
      memValid = ($urandom_range(0, 9) < 6);
      memRegister = 5'($urandom_range(0, 31));
      memData = $urandom;
      issueValid = ($urandom_range(0, 9) < 3);
      issueRegister = 5'($urandom_range(0, 31));
      if (aluValid && memValid) begin
        alu_win = (lost >= 4);
        mem_win = !alu_win;
      end else begin
        alu_win = aluValid;
        mem_win = memValid;
      end
      #1;
      n_vec++;
      if (aluReady !== alu_win || memReady !== mem_win) begin
        n_err++;
        $display("FAIL rand_grant c=%0d: alu=%b mem=%b expected %b %b",
                 c, aluReady, memReady, alu_win, mem_win);
      end
      if (!aluValid || alu_win) lost = 0;
      else if (lost < 4) lost++;
      m_we = 0;
      if (alu_win || mem_win) begin
        m_reg  = alu_win ? aluRegister : memRegister;
        m_data = alu_win ? aluData : memData;
        m_we   = (m_reg != 0);
        m_busy[m_reg] = 0;
      end
      if (issueValid && issueRegister != 0) m_busy[issueRegister] = 1;
      exp_mask = '0;
      for (int r = 1; r < 32; r++) exp_mask[r] = m_busy[r];
      tick();
      n_vec++;
      if (regWrite !== m_we || writeRegister !== m_reg || writeData !== m_data ||
          busyMask !== exp_mask) begin
        n_err++;
        $display("FAIL rand_port c=%0d: we=%b reg=%0d data=%h busy=%h expected %b %0d %h %h",
                 c, regWrite, writeRegister, writeData, busyMask, m_we, m_reg, m_data, exp_mask);
      end
      $display("random c=%0d: we=%b reg=%0d busy=%h", c, regWrite, writeRegister, busyMask);
    end
    idle();
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_reset_midcycle();
    test_collision();
    test_starvation();
    test_reg_zero();
    test_scoreboard();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
